// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between IF reads and MEM loads/stores
// with starvation guard, wait-state tolerant req/ack handshake and timeout abort.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  output logic        if_stall_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_sel_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,
  output logic        mem_stall_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_sel_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        err_o
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;
  state_t state, state_n;
  logic [3:0] starve;
  logic [15:0] tcnt;
  logic if_ok, mem_ok, grant_if, grant_mem, done, tout, fin;
  // a requester being acked this cycle is masked so a held req is not re-granted
  always_comb begin
    if_ok = if_req_i & ~if_ack_o;
    mem_ok = mem_req_i & ~mem_ack_o;
    grant_if = (state == IDLE) & if_ok & (~mem_ok | (starve == 4'(STARVE_LIMIT)));
    grant_mem = (state == IDLE) & mem_ok & ~grant_if;
    done = (state != IDLE) & bus_ack_i;
    tout = (state != IDLE) & ~bus_ack_i & (TIMEOUT != 0) & (tcnt == 16'(TIMEOUT - 1));
    fin = done | tout;
    state_n = grant_if ? BUSY_IF : grant_mem ? BUSY_MEM : fin ? IDLE : state;
  end
  assign if_stall_o = rst & if_req_i & ~if_ack_o;
  assign mem_stall_o = rst & mem_req_i & ~mem_ack_o;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      starve <= '0;
      tcnt <= '0;
      bus_req_o <= 1'b0;
      bus_we_o <= 1'b0;
      bus_addr_o <= '0;
      bus_wdata_o <= '0;
      bus_sel_o <= '0;
      if_ack_o <= 1'b0;
      mem_ack_o <= 1'b0;
      if_rdata_o <= '0;
      mem_rdata_o <= '0;
      err_o <= 1'b0;
    end else begin
      state <= state_n;
      starve <= grant_if ? 4'd0 : (grant_mem & if_ok & (starve != 4'(STARVE_LIMIT))) ? starve + 4'd1 : starve;
      tcnt <= ((state == IDLE) | fin) ? 16'd0 : tcnt + 16'd1;
      if_ack_o <= fin & (state == BUSY_IF);
      mem_ack_o <= fin & (state == BUSY_MEM);
      err_o <= tout;
      if (fin & (state == BUSY_IF)) if_rdata_o <= done ? bus_rdata_i : '0;
      if (fin & (state == BUSY_MEM)) mem_rdata_o <= done ? bus_rdata_i : '0;
      if (grant_if | grant_mem) begin
        bus_req_o <= 1'b1;
        bus_we_o <= grant_mem & mem_we_i;
        bus_addr_o <= grant_mem ? mem_addr_i : if_addr_i;
        bus_wdata_o <= grant_mem ? mem_wdata_i : '0;
        bus_sel_o <= grant_mem ? mem_sel_i : 4'hF;
      end else if (fin) bus_req_o <= 1'b0;
    end
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-ported unified memory bus between the instruction-fetch requester (IF) and the MEM-stage load/store requester.
- Sequences each access with a req/ack handshake and tolerates variable memory wait states.
- Generates per-requester stall requests toward the pipeline controller.
- Sits between the IF/MEM stages and the external memory interface.

Parameters:
- STARVE_LIMIT, 4, consecutive arbitrations IF may lose to MEM before IF is forced to win the next one (1..15).
- TIMEOUT, 64, cycles a granted access may wait for bus_ack_i before it is aborted; 0 disables the timeout.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-low (rst==0 resets)
- if_req_i  input  1  IF read request, level, held until if_ack_o
- if_addr_i  input  32  IF read address
- if_rdata_o  output  32  IF read data, valid when if_ack_o
- if_ack_o  output  1  one-cycle IF completion pulse
- if_stall_o  output  1  IF stall request
- mem_req_i  input  1  MEM request, level, held until mem_ack_o
- mem_we_i  input  1  MEM write enable (1=store)
- mem_addr_i  input  32  MEM address
- mem_wdata_i  input  32  MEM store data
- mem_sel_i  input  4  MEM byte lane select
- mem_rdata_o  output  32  MEM load data, valid when mem_ack_o
- mem_ack_o  output  1  one-cycle MEM completion pulse
- mem_stall_o  output  1  MEM stall request
- bus_req_o  output  1  memory bus request
- bus_we_o  output  1  memory bus write enable
- bus_addr_o  output  32  memory bus address
- bus_wdata_o  output  32  memory bus write data
- bus_sel_o  output  4  memory bus byte select
- bus_rdata_i  input  32  memory bus read data
- bus_ack_i  input  1  memory bus completion, sampled only while bus_req_o=1
- err_o  output  1  one-cycle timeout error pulse, coincident with the aborted ack

Behaviour:
- Reset (rst==0 at a clock edge):
  - State IDLE; starve and timeout counters 0.
  - All registered outputs 0: bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o, if_ack_o, mem_ack_o, if_rdata_o, mem_rdata_o, err_o.
  - Reset during an access abandons it: bus_req_o is 0 from the next cycle and no ack is issued.
- States: IDLE, BUSY_IF, BUSY_MEM.
- IDLE arbitration:
  - A requester whose ack_o is 1 in the current cycle is masked, so a held req is never granted twice.
  - Both eligible: MEM wins unless starve count == STARVE_LIMIT, in which case IF wins.
  - Only one eligible: that one wins.
- Starve counter:
  - Increments when MEM wins while IF is also eligible.
  - Clears whenever IF is granted.
  - Saturates at STARVE_LIMIT.
- Grant (edge at end of IDLE cycle):
  - Latch winner's fields onto bus_* outputs; bus_req_o=1; enter BUSY_x.
  - An IF grant drives bus_we_o=0 and bus_sel_o=4'b1111.
- BUSY_x:
  - bus_* outputs are held stable.
  - Timeout counter increments each cycle bus_ack_i=0.
  - On bus_ack_i=1: next cycle bus_req_o=0, x_ack_o=1 for exactly one cycle, x_rdata_o=bus_rdata_i (stores also capture it, with the value don't-care), state returns to IDLE, timeout counter clears.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no ack: next cycle bus_req_o=0, x_ack_o=1, x_rdata_o=0, err_o=1, state IDLE.
  - A bus_ack_i that coincides with the timeout boundary wins: normal completion, err_o=0.
- Latency:
  - req first visible in IDLE at cycle 0 -> bus_req_o=1 at cycle 1.
  - bus_ack_i at cycle k -> x_ack_o at cycle k+1.
  - Next grant is decided in cycle k+1, so the earliest following bus_req_o=1 is at cycle k+2.
- Stall (combinational):
  - if_stall_o = if_req_i & ~if_ack_o.
  - mem_stall_o = mem_req_i & ~mem_ack_o.
  - Both are 0 during reset.
- Request dropped while granted: the access still completes on the bus, and its ack pulse is still issued.
- bus_ack_i while bus_req_o=0: ignored.
- Data widths are passed through unmodified; no byte-lane alignment is performed here.

Test Plan:
- Single IF read: if_req_i=1, addr=0x0000_0100; memory acks 2 cycles after bus_req_o with 0x2402_0005 -> bus_req_o at cycle 1, bus_addr_o=0x100, bus_sel_o=4'hF, if_ack_o one pulse at cycle 4, if_rdata_o=0x2402_0005, if_stall_o high cycles 0-3.
- Simultaneous requests: IF read 0x200 and MEM store addr 0x8000_0010, data 0xDEAD_BEEF, sel 4'b0011 -> MEM granted first with bus_we_o=1 and correct data/sel; IF granted next; no request is granted twice.
- Starvation: MEM re-requests continuously with IF held high, STARVE_LIMIT=4 -> 4 MEM grants, then the 5th grant goes to IF; starve counter clears afterwards.
- Timeout: TIMEOUT=8, MEM load, bus_ack_i never asserted -> bus_req_o falls after 8 busy cycles; mem_ack_o=1, err_o=1 and mem_rdata_o=0 in the same cycle; state IDLE; a later IF access completes normally.
- Ack at boundary: TIMEOUT=8, bus_ack_i on the 8th busy cycle with 0x1234_5678 -> normal ack, err_o=0, rdata=0x1234_5678.
- Reset mid-access: rst=0 while BUSY_IF -> next cycle bus_req_o=0, no if_ack_o, all outputs 0; after rst=1, a fresh MEM request is granted in 1 cycle.
